adder_error_monitor: RTL and testbench
======================================

# adder_error_monitor

Synthesizable streaming error-metrics engine for approximate adders. It accepts (exact, approximate) sum pairs over a valid/ready handshake and accumulates the raw statistics used to report ER, MED, NMED and bias:
- error count
- sum of absolute error distance
- maximum error distance
- signed error sum
- count of zero exact results (the MRED denominator correction)

It sits beside any approximate adder under test in FPGA/on-chip evaluation, replacing long software simulation runs; host software performs the final divisions.

## Interface
- N, 16, operand/sum width in bits.
- NUM_SAMPLES, 10000000, samples per run (≥1).
- CNT_W, $clog2(NUM_SAMPLES+1), sample/count width.
- ACC_W, N+CNT_W, absolute-sum accumulator width; cannot overflow.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  pulse; clears accumulators and begins a run (IDLE or DONE only).
- in_valid  in  1  sample present.
- in_ready  out  1  block accepts sample this cycle.
- exact_s  in  N  accurate sum (unsigned, truncated to N bits).
- approx_s  in  N  approximate-adder sum (unsigned).
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; results stable.
- sample_cnt  out  CNT_W  samples accepted this run.
- err_cnt  out  CNT_W  samples with approx_s != exact_s.
- zero_cnt  out  CNT_W  samples with exact_s == 0.
- sum_ed  out  ACC_W  Σ|approx_s − exact_s|.
- max_ed  out  N  maximum |approx_s − exact_s|.
- sum_sed  out  ACC_W+1  signed Σ(approx_s − exact_s), two's complement.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE→RUN on start.
  - RUN→DRAIN on the cycle the NUM_SAMPLES-th sample is accepted.
  - DRAIN→DONE when the pipeline is empty.
  - DONE→RUN on start. DONE otherwise holds indefinitely.
- start clears every accumulator and sample_cnt to 0 in the same edge that enters RUN.
- start in RUN or DRAIN is ignored.
- in_ready = (state == RUN). Accept = in_valid & in_ready. in_valid while not ready is dropped, not queued.
- Per accepted sample, computed on the exact N-bit values with no wrap:
  - ed = (approx_s > exact_s) ? approx_s − exact_s : exact_s − approx_s, range 0..2^N−1.
  - sed = approx_s − exact_s as an N+1-bit signed value.
- Accumulation:
  - err_cnt += (ed != 0).
  - zero_cnt += (exact_s == 0).
  - sum_ed += ed.
  - sum_sed += sign-extended sed.
  - max_ed = max(max_ed, ed).
- Widths guarantee no overflow for NUM_SAMPLES samples, so no saturation logic is needed.
- Outputs are live during RUN and defined final only while done = 1.

## Timing
- Reset (rst_n low at an edge):
  - State goes to IDLE; all outputs and accumulators go to 0.
  - in_ready, busy and done are 0.
  - Reset mid-run discards the run; no partial results are kept.
- Pipeline:
  - Stage 1 registers ed, sed, the err flag and the zero flag.
  - Stage 2 updates the accumulators.
  - An accumulator reflects a sample 2 cycles after its accept edge.
- sample_cnt increments on the accept edge.
- in_ready falls the cycle after the final accept.
- done rises exactly 2 cycles after the final accept edge.
- Back-to-back accepts are sustained at 1 sample/cycle. Gaps in in_valid insert no extra latency.
- A start edge out of DONE drops done the next cycle and raises in_ready the same cycle.

## Structure
- Package adder_metrics_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE)
  - width helper functions for CNT_W and ACC_W
- Sub-module error_distance_unit (parameter N) is stage 1. It takes exact_s, approx_s and a valid bit, and registers ed, sed, is_err, is_zero and valid.
- The top level holds the FSM, counters and stage-2 accumulators.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles → all outputs 0, in_ready = 0, done = 0. Then rst_n = 1 with no start → IDLE persists.
- Basic run (N = 16, NUM_SAMPLES = 4), start then pairs (exact, approx) = (100,100), (100,90), (5,25), (0,0) back-to-back → required results:
  - err_cnt = 2, sum_ed = 30, max_ed = 20, sum_sed = +10, zero_cnt = 1, sample_cnt = 4.
  - done is high exactly 2 cycles after the 4th accept.
- Gaps/backpressure: same 4 samples with in_valid low for 3 cycles between each → identical results. An in_valid pulse after the 4th accept is not counted.
- Extremes: 4 samples of exact = 0xFFFF, approx = 0x0000 → max_ed = 65535, sum_ed = 262140, sum_sed = −262140, err_cnt = 4, zero_cnt = 0.
- Restart: start during RUN is ignored (counts continue). start in DONE clears all accumulators; a following run of 4 error-free samples → err_cnt = 0, sum_ed = 0.
- Mid-run reset: rst_n = 0 after 2 accepts → next edge all zero, IDLE. A new start then runs a clean 4-sample run correctly.

Source files
------------

// File: rtl/adder_metrics_pkg.sv
// Shared definitions for the approximate-adder error-metrics engine.
//   state_t   : run-control states (IDLE, RUN, DRAIN, DONE)
//   cnt_width : width of a counter that must hold 0..num_samples
//   acc_width : width of the absolute-error accumulator (never overflows)
package adder_metrics_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int cnt_width(input int num_samples);
    return $clog2(num_samples + 1);
  endfunction

  // Each sample adds at most 2^n - 1, so n extra bits over the count suffice.
  function automatic int acc_width(input int n, input int num_samples);
    return n + cnt_width(num_samples);
  endfunction

endpackage

// File: rtl/error_distance_unit.sv
// Stage 1 of the metrics pipeline: per-sample error distance.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   i_valid             : sample accepted this cycle
//   i_exact, i_approx   : exact and approximate N-bit sums (unsigned)
//   o_ed                : |approx - exact|, registered
//   o_sed               : approx - exact as N+1-bit signed, registered
//   o_is_err, o_is_zero : ed != 0, exact == 0, registered
//   o_valid             : registered sample valid
module error_distance_unit #(
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  input  logic [N-1:0]        i_exact,
  input  logic [N-1:0]        i_approx,
  output logic [N-1:0]        o_ed,
  output logic signed [N:0]   o_sed,
  output logic                o_is_err,
  output logic                o_is_zero,
  output logic                o_valid
);

  logic [N-1:0]        w_ed;
  logic signed [N:0]   w_sed;

  logic                r_vld_p1;
  logic [N-1:0]        r_ed_p1;
  logic signed [N:0]   r_sed_p1;
  logic                r_is_err_p1;
  logic                r_is_zero_p1;

  // Zero-extending both operands by one bit keeps the difference exact.
  always_comb begin
    w_sed = $signed({1'b0, i_approx}) - $signed({1'b0, i_exact});
    w_ed  = (i_approx > i_exact) ? (i_approx - i_exact) : (i_exact - i_approx);
  end

  // ---- stage 1 register: valid is reset, data only loads on a valid sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= i_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (i_valid) begin
      r_ed_p1      <= w_ed;
      r_sed_p1     <= w_sed;
      r_is_err_p1  <= (w_ed != '0);
      r_is_zero_p1 <= (i_exact == '0);
    end
  end

  assign o_valid   = r_vld_p1;
  assign o_ed      = r_ed_p1;
  assign o_sed     = r_sed_p1;
  assign o_is_err  = r_is_err_p1;
  assign o_is_zero = r_is_zero_p1;

endmodule

// File: rtl/adder_error_monitor.sv
// Streaming error-metrics engine for approximate adders. Accepts
// (exact, approximate) sum pairs and accumulates the raw statistics for
// ER, MED, NMED and bias; host software does the final divisions.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : clears accumulators and begins a run (IDLE/DONE only)
//   in_valid / in_ready : sample handshake; unaccepted samples are dropped
//   exact_s, approx_s   : exact and approximate N-bit sums
//   busy, done          : run in progress / results final and stable
//   sample_cnt          : samples accepted this run
//   err_cnt, zero_cnt   : samples with error / with exact == 0
//   sum_ed, max_ed      : sum and maximum of |approx - exact|
//   sum_sed             : signed sum of (approx - exact), two's complement
module adder_error_monitor
  import adder_metrics_pkg::*;
#(
  parameter  int N           = 16,
  parameter  int NUM_SAMPLES = 10000000,
  localparam int CNT_W       = cnt_width(NUM_SAMPLES),
  localparam int ACC_W       = acc_width(N, NUM_SAMPLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     exact_s,
  input  logic [N-1:0]     approx_s,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] zero_cnt,
  output logic [ACC_W-1:0] sum_ed,
  output logic [N-1:0]     max_ed,
  output logic [ACC_W:0]   sum_sed
);

  state_t r_state, w_state_nxt;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_start_ok;

  logic                  w_vld_p1;
  logic [N-1:0]          w_ed_p1;
  logic signed [N:0]     w_sed_p1;
  logic                  w_is_err_p1;
  logic                  w_is_zero_p1;

  logic [CNT_W-1:0]      r_sample_cnt;
  logic [CNT_W-1:0]      r_err_cnt_p2;
  logic [CNT_W-1:0]      r_zero_cnt_p2;
  logic [ACC_W-1:0]      r_sum_ed_p2;
  logic [N-1:0]          r_max_ed_p2;
  logic signed [ACC_W:0] r_sum_sed_p2;

  assign w_accept   = in_valid && (r_state == RUN);
  assign w_last     = w_accept && (r_sample_cnt == CNT_W'(NUM_SAMPLES - 1));
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // DRAIN waits for the last sample to leave stage 1, so done rises two
  // edges after the final accept with all accumulators already settled.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!w_vld_p1) w_state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) w_state_nxt = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---- stage 0: accept edge, sample counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sample_cnt <= '0;
    end else if (w_start_ok) begin
      r_sample_cnt <= '0;
    end else if (w_accept) begin
      r_sample_cnt <= r_sample_cnt + 1'b1;
    end
  end

  // ---- stage 1: error distance
  error_distance_unit #(
    .N (N)
  ) u_edu (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (w_accept),
    .i_exact   (exact_s),
    .i_approx  (approx_s),
    .o_ed      (w_ed_p1),
    .o_sed     (w_sed_p1),
    .o_is_err  (w_is_err_p1),
    .o_is_zero (w_is_zero_p1),
    .o_valid   (w_vld_p1)
  );

  // ---- stage 2: accumulators
  // start is only honoured in IDLE/DONE, where stage 1 is always empty, so
  // clearing never collides with an in-flight sample.
  always_ff @(posedge clk) begin
    if (!rst_n || w_start_ok) begin
      r_err_cnt_p2  <= '0;
      r_zero_cnt_p2 <= '0;
      r_sum_ed_p2   <= '0;
      r_max_ed_p2   <= '0;
      r_sum_sed_p2  <= '0;
    end else if (w_vld_p1) begin
      r_err_cnt_p2  <= r_err_cnt_p2 + CNT_W'(w_is_err_p1);
      r_zero_cnt_p2 <= r_zero_cnt_p2 + CNT_W'(w_is_zero_p1);
      r_sum_ed_p2   <= r_sum_ed_p2 + ACC_W'(w_ed_p1);
      r_sum_sed_p2  <= r_sum_sed_p2 + (ACC_W + 1)'(w_sed_p1);
      if (w_ed_p1 > r_max_ed_p2) begin
        r_max_ed_p2 <= w_ed_p1;
      end
    end
  end

  assign sample_cnt = r_sample_cnt;
  assign err_cnt    = r_err_cnt_p2;
  assign zero_cnt   = r_zero_cnt_p2;
  assign sum_ed     = r_sum_ed_p2;
  assign max_ed     = r_max_ed_p2;
  assign sum_sed    = r_sum_sed_p2;

endmodule

// File: tb/tb_adder_error_monitor.sv
// Scoreboard bench for adder_error_monitor (N = 16, NUM_SAMPLES = 4).
// Each run pushes its hand-computed result set; a monitor pops and compares
// when done rises, and also checks the accept-to-done latency.
module tb_adder_error_monitor;

  localparam int N     = 16;
  localparam int NS    = 4;
  localparam int CNT_W = $clog2(NS + 1);
  localparam int ACC_W = N + CNT_W;

  logic             clk = 1'b0;
  logic             rst_n, start, in_valid, in_ready, busy, done;
  logic [N-1:0]     exact_s, approx_s, max_ed;
  logic [CNT_W-1:0] sample_cnt, err_cnt, zero_cnt;
  logic [ACC_W-1:0] sum_ed;
  logic [ACC_W:0]   sum_sed;

  adder_error_monitor #(.N(N), .NUM_SAMPLES(NS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .exact_s    (exact_s),
    .approx_s   (approx_s),
    .busy       (busy),
    .done       (done),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt),
    .zero_cnt   (zero_cnt),
    .sum_ed     (sum_ed),
    .max_ed     (max_ed),
    .sum_sed    (sum_sed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int smp; int err; int zero; int sed_abs; int mx; int ssed;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_acc = 0;
  logic done_q  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  // Monitor: remember the most recent accept, score results when done rises.
  always @(negedge clk) begin
    exp_t e;
    if (in_valid === 1'b1 && in_ready === 1'b1) last_acc = cyc;
    if (done === 1'b1 && done_q !== 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sample_cnt", int'(sample_cnt), e.smp);
        chk("err_cnt",    int'(err_cnt),    e.err);
        chk("zero_cnt",   int'(zero_cnt),   e.zero);
        chk("sum_ed",     int'(sum_ed),     e.sed_abs);
        chk("max_ed",     int'(max_ed),     e.mx);
        chk("sum_sed",    $signed(sum_sed), e.ssed);
        chk("done_latency", cyc - (last_acc + 1), 2);
      end
    end
    done_q = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // gap = number of idle cycles after each sample
  task automatic send(input logic [N-1:0] ex, input logic [N-1:0] ap, input int gap);
    exact_s  = ex;
    approx_s = ap;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    if (done !== 1'b1) begin
      chk("done_timeout", 0, 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(negedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sample_cnt"}, int'(sample_cnt), 0);
    chk({tag, "_err_cnt"},    int'(err_cnt),    0);
    chk({tag, "_zero_cnt"},   int'(zero_cnt),   0);
    chk({tag, "_sum_ed"},     int'(sum_ed),     0);
    chk({tag, "_max_ed"},     int'(max_ed),     0);
    chk({tag, "_sum_sed"},    int'(sum_sed),    0);
    chk({tag, "_in_ready"},   int'(in_ready),   0);
    chk({tag, "_busy"},       int'(busy),       0);
    chk({tag, "_done"},       int'(done),       0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    exact_s = '0; approx_s = '0;

    // Reset held 3 cycles, then released with no start.
    repeat (3) tick();
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("idle_in_ready", int'(in_ready), 0);
    chk("idle_busy",     int'(busy),     0);
    tick();

    // Basic back-to-back run.
    exp_q.push_back('{4, 2, 1, 30, 20, 10});
    pulse_start();
    chk("run_busy", int'(busy), 1);
    exact_s = 16'd100; approx_s = 16'd100; in_valid = 1'b1; tick();
    exact_s = 16'd100; approx_s = 16'd90;  tick();
    exact_s = 16'd5;   approx_s = 16'd25;  tick();
    exact_s = 16'd0;   approx_s = 16'd0;   tick();
    in_valid = 1'b0;
    wait_done();

    // Same samples with 3-cycle gaps; extra in_valid pulse during drain.
    exp_q.push_back('{4, 2, 1, 30, 20, 10});
    pulse_start();
    chk("restart_ready", int'(in_ready), 1);
    chk("restart_done",  int'(done),     0);
    send(16'd100, 16'd100, 3);
    send(16'd100, 16'd90,  3);
    send(16'd5,   16'd25,  3);
    send(16'd0,   16'd0,   0);
    send(16'd77,  16'd1,   0);
    wait_done();
    send(16'd9, 16'd1, 1);
    chk("done_drop_cnt",   int'(sample_cnt), 4);
    chk("done_drop_err",   int'(err_cnt),    2);
    chk("done_hold",       int'(done),       1);

    // Extremes.
    exp_q.push_back('{4, 4, 0, 262140, 65535, -262140});
    pulse_start();
    repeat (4) send(16'hFFFF, 16'h0000, 0);
    wait_done();

    // start during RUN is ignored.
    exp_q.push_back('{4, 3, 1, 11, 5, 3});
    pulse_start();
    send(16'd10, 16'd12, 0);
    send(16'd7,  16'd3,  0);
    pulse_start();
    chk("ignored_start_cnt", int'(sample_cnt), 2);
    send(16'd1, 16'd1, 0);
    send(16'd0, 16'd5, 0);
    wait_done();

    // start in DONE clears, then an error-free run.
    exp_q.push_back('{4, 0, 0, 0, 0, 0});
    pulse_start();
    chk("clear_sample_cnt", int'(sample_cnt), 0);
    chk("clear_sum_ed",     int'(sum_ed),     0);
    chk("clear_max_ed",     int'(max_ed),     0);
    send(16'd50,    16'd50,    0);
    send(16'd1,     16'd1,     0);
    send(16'hFFFF,  16'hFFFF,  0);
    send(16'd200,   16'd200,   0);
    wait_done();

    // Mid-run reset after 2 accepts.
    pulse_start();
    send(16'd3, 16'd40, 0);
    send(16'd0, 16'd6,  0);
    tick();
    chk("pre_rst_cnt", int'(sample_cnt), 2);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk_all_zero("midrst");
    rst_n = 1'b1;
    tick();
    exp_q.push_back('{4, 2, 2, 11, 9, -7});
    pulse_start();
    send(16'd3, 16'd3, 0);
    send(16'd0, 16'd2, 0);
    send(16'd9, 16'd0, 0);
    send(16'd0, 16'd0, 0);
    wait_done();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
